// File: rtl/ex_hazard_ctrl_if.sv
// Pipeline-side signal bundle for the EX hazard/forwarding controller.
// slave = the controller, master = the pipeline that drives it.
interface ex_hazard_ctrl_if;
  logic [4:0]  id_rs1;
  logic [4:0]  id_rs2;
  logic        id_useRs1;
  logic        id_useRs2;
  logic [4:0]  id_exRs1;
  logic [4:0]  id_exRs2;
  logic [4:0]  id_exRd;
  logic        id_exMemRead;
  logic [4:0]  ex_memRd;
  logic        ex_memRegWrite;
  logic [4:0]  mem_wbRd;
  logic        mem_wbRegWrite;
  logic        ex_mdStart;
  logic        ex_flush;
  logic [1:0]  fwdA;
  logic [1:0]  fwdB;
  logic        pcWrite;
  logic        if_idWrite;
  logic        id_exWrite;
  logic        id_exBubble;
  logic        ex_memBubble;
  logic [31:0] stallCount;

  modport slave (
    input  id_rs1, id_rs2, id_useRs1, id_useRs2, id_exRs1, id_exRs2, id_exRd,
           id_exMemRead, ex_memRd, ex_memRegWrite, mem_wbRd, mem_wbRegWrite,
           ex_mdStart, ex_flush,
    output fwdA, fwdB, pcWrite, if_idWrite, id_exWrite, id_exBubble,
           ex_memBubble, stallCount
  );

  modport master (
    output id_rs1, id_rs2, id_useRs1, id_useRs2, id_exRs1, id_exRs2, id_exRd,
           id_exMemRead, ex_memRd, ex_memRegWrite, mem_wbRd, mem_wbRegWrite,
           ex_mdStart, ex_flush,
    input  fwdA, fwdB, pcWrite, if_idWrite, id_exWrite, id_exBubble,
           ex_memBubble, stallCount
  );
endinterface

// File: rtl/ex_hazard_ctrl.sv
// RV32 EX-stage forwarding selects, load-use stall and mul/div freeze sequencer.
// Define EX_HAZARD_PERF_CNT_EN to enable the stall-cycle counter on stallCount.
module ex_hazard_ctrl #(
  parameter int unsigned MD_LATENCY = 4,
  parameter int unsigned MD_CNT_W   = 4
) (
  input logic              clk,
  input logic              rst_n,
  ex_hazard_ctrl_if.slave  bus
);

  typedef enum logic {IDLE, MD_BUSY} state_t;

  localparam logic [MD_CNT_W-1:0] MD_LOAD = MD_CNT_W'(MD_LATENCY - 2);

  state_t              r_state;
  logic [MD_CNT_W-1:0] r_mdCnt;

  logic [1:0] w_fwdA;
  logic [1:0] w_fwdB;
  logic       w_loadUse;
  logic       w_stall;
  logic       w_pcWrite;
  logic       w_ifIdWrite;
  logic       w_idExWrite;
  logic       w_idExBubble;
  logic       w_exMemBubble;

  // EX/MEM has priority over WB; x0 never forwards.
  always_comb begin
    w_fwdA = 2'b00;
    w_fwdB = 2'b00;
    if (bus.ex_memRegWrite && bus.ex_memRd != 5'd0 && bus.ex_memRd == bus.id_exRs1)
      w_fwdA = 2'b10;
    else if (bus.mem_wbRegWrite && bus.mem_wbRd != 5'd0 && bus.mem_wbRd == bus.id_exRs1)
      w_fwdA = 2'b01;
    if (bus.ex_memRegWrite && bus.ex_memRd != 5'd0 && bus.ex_memRd == bus.id_exRs2)
      w_fwdB = 2'b10;
    else if (bus.mem_wbRegWrite && bus.mem_wbRd != 5'd0 && bus.mem_wbRd == bus.id_exRs2)
      w_fwdB = 2'b01;
  end

  assign w_loadUse = bus.id_exMemRead && (bus.id_exRd != 5'd0) &&
                     ((bus.id_useRs1 && bus.id_rs1 == bus.id_exRd) ||
                      (bus.id_useRs2 && bus.id_rs2 == bus.id_exRd));

  // A redirect or a mul/div start in the same cycle overrides the load-use stall.
  assign w_stall = (r_state == IDLE) && w_loadUse && !bus.ex_flush && !bus.ex_mdStart;

  always_comb begin
    w_pcWrite     = 1'b1;
    w_ifIdWrite   = 1'b1;
    w_idExWrite   = 1'b1;
    w_idExBubble  = 1'b0;
    w_exMemBubble = 1'b0;
    if (!rst_n) begin
      w_pcWrite = 1'b1;
    end else if (r_state == MD_BUSY) begin
      w_pcWrite     = 1'b0;
      w_ifIdWrite   = 1'b0;
      w_idExWrite   = 1'b0;
      w_exMemBubble = 1'b1;
    end else if (w_stall) begin
      w_pcWrite    = 1'b0;
      w_ifIdWrite  = 1'b0;
      w_idExBubble = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_mdCnt <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.ex_mdStart) begin
            r_state <= MD_BUSY;
            r_mdCnt <= MD_LOAD;
          end
        end
        MD_BUSY: begin
          if (r_mdCnt == '0) r_state <= IDLE;
          else               r_mdCnt <= r_mdCnt - MD_CNT_W'(1);
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef EX_HAZARD_PERF_CNT_EN
  logic [31:0] r_stallCount;

  always_ff @(posedge clk) begin
    if (!rst_n)          r_stallCount <= '0;
    else if (!w_pcWrite) r_stallCount <= r_stallCount + 32'd1;
  end

  assign bus.stallCount = r_stallCount;
`else
  assign bus.stallCount = '0;
`endif

  assign bus.fwdA         = rst_n ? w_fwdA : 2'b00;
  assign bus.fwdB         = rst_n ? w_fwdB : 2'b00;
  assign bus.pcWrite      = w_pcWrite;
  assign bus.if_idWrite   = w_ifIdWrite;
  assign bus.id_exWrite   = w_idExWrite;
  assign bus.id_exBubble  = w_idExBubble;
  assign bus.ex_memBubble = w_exMemBubble;

endmodule

// File: tb/tb_ex_hazard_ctrl.sv
// Directed vector bench for ex_hazard_ctrl (MD_LATENCY = 4).
module tb_ex_hazard_ctrl;

  logic clk;
  logic rst_n;

  ex_hazard_ctrl_if ifc ();

  ex_hazard_ctrl #(.MD_LATENCY(4), .MD_CNT_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [4:0] memRd;   logic memRW;
    logic [4:0] wbRd;    logic wbRW;
    logic [4:0] exRs1;   logic [4:0] exRs2;
    logic [4:0] rs1;     logic [4:0] rs2;
    logic       use1;    logic use2;
    logic [4:0] exRd;    logic exMemRead;
    logic       flush;
    logic [8:0] exp;     // {fwdA, fwdB, pcWrite, if_idWrite, id_exWrite, id_exBubble, ex_memBubble}
  } vec_t;

  localparam logic [8:0] IDLE_OUT = 9'b00_00_111_00;
  localparam logic [8:0] STALL    = 9'b00_00_001_10;
  localparam logic [8:0] BUSY     = 9'b00_00_000_01;

  vec_t vecs[12];
  int   n_vec = 0;
  int   n_err = 0;

  logic [8:0] obs;
  assign obs = {ifc.fwdA, ifc.fwdB, ifc.pcWrite, ifc.if_idWrite, ifc.id_exWrite,
                ifc.id_exBubble, ifc.ex_memBubble};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    ifc.id_rs1 = '0;   ifc.id_rs2 = '0;   ifc.id_useRs1 = 1'b0; ifc.id_useRs2 = 1'b0;
    ifc.id_exRs1 = '0; ifc.id_exRs2 = '0; ifc.id_exRd = '0;     ifc.id_exMemRead = 1'b0;
    ifc.ex_memRd = '0; ifc.ex_memRegWrite = 1'b0;
    ifc.mem_wbRd = '0; ifc.mem_wbRegWrite = 1'b0;
    ifc.ex_mdStart = 1'b0; ifc.ex_flush = 1'b0;
  endtask

  task automatic apply(input vec_t v);
    ifc.ex_memRd = v.memRd;   ifc.ex_memRegWrite = v.memRW;
    ifc.mem_wbRd = v.wbRd;    ifc.mem_wbRegWrite = v.wbRW;
    ifc.id_exRs1 = v.exRs1;   ifc.id_exRs2 = v.exRs2;
    ifc.id_rs1 = v.rs1;       ifc.id_rs2 = v.rs2;
    ifc.id_useRs1 = v.use1;   ifc.id_useRs2 = v.use2;
    ifc.id_exRd = v.exRd;     ifc.id_exMemRead = v.exMemRead;
    ifc.ex_flush = v.flush;   ifc.ex_mdStart = 1'b0;
  endtask

  task automatic set_loaduse();
    ifc.id_exMemRead = 1'b1; ifc.id_exRd = 5'd3; ifc.id_rs1 = 5'd3; ifc.id_useRs1 = 1'b1;
  endtask

  // Start cycle plus three frozen cycles, then back to IDLE.
  task automatic md_op(input string tag);
    @(negedge clk); clear_inputs(); ifc.ex_mdStart = 1'b1; #1;
    check({tag, "_start"}, {23'd0, obs}, {23'd0, IDLE_OUT});
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk); clear_inputs(); #1;
      check($sformatf("%s_busy%0d", tag, i), {23'd0, obs}, {23'd0, BUSY});
    end
    @(negedge clk); clear_inputs(); #1;
    check({tag, "_done"}, {23'd0, obs}, {23'd0, IDLE_OUT});
  endtask

  initial begin
    //           name        memRd memRW wbRd wbRW exRs1 exRs2 rs1  rs2  u1 u2 exRd  mr fl exp
    vecs[0]  = '{"mem_fwdB",   5,  1,    0,  0,   6,    5,    0,   0,  0, 0,  0,   0, 0, 9'b00_10_111_00};
    vecs[1]  = '{"dbl_mem",    7,  1,    7,  1,   7,    0,    0,   0,  0, 0,  0,   0, 0, 9'b10_00_111_00};
    vecs[2]  = '{"dbl_wb",     7,  0,    7,  1,   7,    0,    0,   0,  0, 0,  0,   0, 0, 9'b01_00_111_00};
    vecs[3]  = '{"x0_nofwd",   0,  1,    0,  1,   0,    0,    0,   0,  0, 0,  0,   0, 0, IDLE_OUT};
    vecs[4]  = '{"wb_fwdB",    4,  1,    9,  1,   2,    9,    0,   0,  0, 0,  0,   0, 0, 9'b00_01_111_00};
    vecs[5]  = '{"both_ops",  12,  1,   13,  1,  13,   12,    0,   0,  0, 0,  0,   0, 0, 9'b01_10_111_00};
    vecs[6]  = '{"lu_rs1",     0,  0,    0,  0,   0,    0,    3,   0,  1, 0,  3,   1, 0, STALL};
    vecs[7]  = '{"lu_flush",   0,  0,    0,  0,   0,    0,    3,   0,  1, 0,  3,   1, 1, IDLE_OUT};
    vecs[8]  = '{"lu_nouse",   0,  0,    0,  0,   0,    0,    0,   8,  0, 0,  8,   1, 0, IDLE_OUT};
    vecs[9]  = '{"lu_rs2",     0,  0,    0,  0,   0,    0,    0,   8,  0, 1,  8,   1, 0, STALL};
    vecs[10] = '{"lu_x0",      0,  0,    0,  0,   0,    0,    0,   0,  1, 1,  0,   1, 0, IDLE_OUT};
    vecs[11] = '{"lu_noload",  0,  0,    0,  0,   0,    0,    3,   0,  1, 0,  3,   0, 0, IDLE_OUT};

    // Reset: outputs forced even with forwarding and load-use inputs active.
    rst_n = 1'b0;
    clear_inputs();
    ifc.ex_memRegWrite = 1'b1; ifc.ex_memRd = 5'd5; ifc.id_exRs1 = 5'd5;
    set_loaduse();
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    check("reset_out", {23'd0, obs}, {23'd0, IDLE_OUT});
    check("reset_cnt", ifc.stallCount, 32'd0);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      @(negedge clk);
      apply(vecs[i]);
      #1;
      check(vecs[i].name, {23'd0, obs}, {23'd0, vecs[i].exp});
    end

    // Stall lasts one cycle once the load has moved on.
    @(negedge clk); clear_inputs(); #1;
    check("lu_after", {23'd0, obs}, {23'd0, IDLE_OUT});

    // mdStart beats a simultaneous load-use hazard; busy ignores flush/mdStart, fwd still tracks.
    @(negedge clk); clear_inputs(); set_loaduse(); ifc.ex_mdStart = 1'b1; #1;
    check("md_prio", {23'd0, obs}, {23'd0, IDLE_OUT});
    @(negedge clk); clear_inputs(); #1;
    check("md_b1", {23'd0, obs}, {23'd0, BUSY});
    @(negedge clk); clear_inputs(); set_loaduse(); ifc.ex_flush = 1'b1; ifc.ex_mdStart = 1'b1;
    ifc.ex_memRegWrite = 1'b1; ifc.ex_memRd = 5'd5; ifc.id_exRs1 = 5'd5; #1;
    check("md_b2_fwd", {23'd0, obs}, {23'd0, 9'b10_00_000_01});
    @(negedge clk); clear_inputs(); #1;
    check("md_b3", {23'd0, obs}, {23'd0, BUSY});
    @(negedge clk); clear_inputs(); #1;
    check("md_idle", {23'd0, obs}, {23'd0, IDLE_OUT});

    // Reset in the second busy cycle aborts the freeze at once.
    @(negedge clk); clear_inputs(); ifc.ex_mdStart = 1'b1;
    @(negedge clk); clear_inputs(); #1;
    check("rst_b1", {23'd0, obs}, {23'd0, BUSY});
    @(negedge clk); rst_n = 1'b0;
    ifc.ex_memRegWrite = 1'b1; ifc.ex_memRd = 5'd5; ifc.id_exRs1 = 5'd5; #1;
    check("rst_b2_forced", {23'd0, obs}, {23'd0, IDLE_OUT});
    @(negedge clk); rst_n = 1'b1; clear_inputs(); #1;
    check("rst_release", {23'd0, obs}, {23'd0, IDLE_OUT});
    md_op("md_after_rst");

    // Stall counter: one load-use cycle plus three frozen cycles.
    @(negedge clk); rst_n = 1'b0; clear_inputs();
    @(negedge clk); rst_n = 1'b1; set_loaduse(); #1;
    check("perf_lu", {23'd0, obs}, {23'd0, STALL});
    md_op("perf_md");
`ifdef EX_HAZARD_PERF_CNT_EN
    check("stall_count", ifc.stallCount, 32'd4);
`else
    check("stall_count", ifc.stallCount, 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
